// File: rtl/ones_count_datapath.sv
// Datapath for a ones-counting engine: one-deep input buffer, shift register N,
// saturating Count register, status flags and an OE-edge-triggered result latch.
module ones_count_datapath #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned TARGET = 4,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             NMUX,
  input  logic             CountMUX,
  input  logic             NLoad,
  input  logic             CountLoad,
  input  logic             OutputMUX,
  input  logic             OE,
  output logic             N_equal_0,
  output logic             N0_equal_0,
  output logic             Count_equal_4,
  output logic             result,
  output logic             result_valid,
  output logic [CW-1:0]    count_out
);

  logic [WIDTH-1:0] din_buf;
  logic             buf_full;
  logic [WIDTH-1:0] n_q;
  logic [CW-1:0]    count_q;
  logic             oe_q;
  logic             accept;
  logic             oe_rise;

  assign din_ready = !buf_full;
  assign accept    = din_valid && !buf_full;
  assign oe_rise   = OE && !oe_q;

  // Input buffer: a fresh capture wins over the drain from an N load on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_buf  <= '0;
      buf_full <= 1'b0;
    end else if (accept) begin
      din_buf  <= din;
      buf_full <= 1'b1;
    end else if (NLoad && NMUX) begin
      buf_full <= 1'b0;
    end
  end

  // N register: parallel load from the buffer or logical right shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q <= '0;
    end else if (NLoad) begin
      if (NMUX) n_q <= din_buf;
      else      n_q <= n_q >> 1;
    end
  end

  // Count register: clear or saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (CountLoad) begin
      if (CountMUX)           count_q <= '0;
      else if (count_q != '1) count_q <= count_q + CW'(1);
    end
  end

  // Result latch fires once per OE rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_q         <= 1'b0;
      result       <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      oe_q         <= OE;
      result_valid <= oe_rise;
      if (oe_rise) result <= OutputMUX;
    end
  end

  assign N_equal_0     = (n_q == '0);
  assign N0_equal_0    = !n_q[0];
  assign Count_equal_4 = (count_q == CW'(TARGET));
  assign count_out     = count_q;

endmodule
